// File: rtl/dpr_pkg.sv
// rtl/dpr_pkg.sv - shared types and constants for the SPI packet receive path
package dpr_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_HDR,
      RX_PAYLOAD,
      RX_DRAIN,
      RX_AVAIL
   } rx_state_t;

   localparam int SPI_WORD_BYTES = 4;

   localparam logic [1:0] RX_ERR_NONE    = 2'd0;
   localparam logic [1:0] RX_ERR_LEN     = 2'd1;
   localparam logic [1:0] RX_ERR_OVERRUN = 2'd2;
   localparam logic [1:0] RX_ERR_ABORT   = 2'd3;

endpackage

// File: rtl/spi_byte_sync.sv
// rtl/spi_byte_sync.sv - SPI mode 0 synchronisers, edge detect and MSB-first byte shifter
module spi_byte_sync (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       ss_n,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_active
);

   logic [1:0] sclk_s;
   logic [1:0] mosi_s;
   logic [1:0] ss_s;
   logic       sclk_d;
   logic       ss_d;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       sclk_rise;

   assign sclk_rise    = sclk_s[1] & ~sclk_d;
   assign frame_start  = ss_d & ~ss_s[1];
   assign frame_end    = ~ss_d & ss_s[1];
   assign frame_active = ~ss_s[1];

   // ss_n syncs reset high so releasing reset with the host idle is not seen as a frame start
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sclk_s     <= 2'b00;
         mosi_s     <= 2'b00;
         ss_s       <= 2'b11;
         sclk_d     <= 1'b0;
         ss_d       <= 1'b1;
         bit_cnt    <= 3'd0;
         shift      <= 7'd0;
         rx_byte    <= 8'd0;
         byte_valid <= 1'b0;
      end else begin
         sclk_s     <= {sclk_s[0], sclk};
         mosi_s     <= {mosi_s[0], mosi};
         ss_s       <= {ss_s[0], ss_n};
         sclk_d     <= sclk_s[1];
         ss_d       <= ss_s[1];
         byte_valid <= 1'b0;
         if (frame_start) begin
            bit_cnt <= 3'd0;
         end else if (sclk_rise && !ss_s[1]) begin
            if (bit_cnt == 3'd7) begin
               rx_byte    <= {shift, mosi_s[1]};
               byte_valid <= 1'b1;
            end else begin
               shift <= {shift[5:0], mosi_s[1]};
            end
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/spi_pkt_rx.sv
// rtl/spi_pkt_rx.sv - SPI slave packet receiver: length header, payload words to memory, packet handle
module spi_pkt_rx
   import dpr_pkg::*;
#(
   parameter int                ADDR_W    = 26,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BUF_BASE  = '0,
   parameter int                MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_ss_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pkt_region_begin,
   output logic [ADDR_W-1:0] pkt_region_end,
   output logic              pkt_avail,
   input  logic              done,
   output logic              rx_busy,
   output logic              rx_err
);

   localparam int WCNT_W = $clog2(MAX_WORDS + 1);

   rx_state_t         state;
   logic [7:0]        rx_byte;
   logic              byte_valid;
   logic              frame_start;
   logic              frame_end;
   logic              frame_active;
   logic [1:0]        byte_cnt;
   logic [23:0]       word_sr;
   logic [31:0]       word;
   logic              in_frame;
   logic              word_done;
   logic              ack_now;
   logic              hdr_ok;
   logic [WCNT_W-1:0] len;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wtaken;

   spi_byte_sync u_sync (
      .clk          (clk),
      .rst_l        (rst_l),
      .sclk         (spi_sclk),
      .mosi         (spi_mosi),
      .ss_n         (spi_ss_n),
      .rx_byte      (rx_byte),
      .byte_valid   (byte_valid),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .frame_active (frame_active)
   );

   // Little-endian assembly: earlier bytes have been shifted down into word_sr
   assign word      = {rx_byte, word_sr};
   assign in_frame  = (state == RX_HDR) || (state == RX_PAYLOAD);
   assign word_done = byte_valid && in_frame && (byte_cnt == 2'(SPI_WORD_BYTES - 1));
   assign ack_now   = mem_we && mem_ack;
   assign hdr_ok    = (word != 32'd0) && (word <= 32'(MAX_WORDS));
   assign rx_busy   = (state != RX_IDLE);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state            <= RX_IDLE;
         byte_cnt         <= 2'd0;
         word_sr          <= 24'd0;
         len              <= '0;
         wcnt             <= '0;
         wtaken           <= '0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         mem_we           <= 1'b0;
         pkt_avail        <= 1'b0;
         pkt_region_begin <= '0;
         pkt_region_end   <= '0;
         rx_err           <= 1'b0;
      end else begin
         rx_err <= 1'b0;
         // A pending write always completes, whatever state the FSM has moved to
         if (ack_now) mem_we <= 1'b0;
         if (byte_valid && in_frame) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {rx_byte, word_sr[23:8]};
         end
         case (state)
            RX_IDLE: begin
               if (frame_start) begin
                  byte_cnt <= 2'd0;
                  state    <= RX_HDR;
               end
            end
            RX_HDR: begin
               if (frame_end) begin
                  rx_err <= 1'b1;
                  state  <= RX_IDLE;
               end else if (word_done) begin
                  if (hdr_ok) begin
                     len    <= WCNT_W'(word);
                     wcnt   <= '0;
                     wtaken <= '0;
                     state  <= RX_PAYLOAD;
                  end else begin
                     rx_err <= 1'b1;
                     state  <= RX_DRAIN;
                  end
               end
            end
            RX_PAYLOAD: begin
               if (ack_now) wcnt <= wcnt + 1'b1;
               if (ack_now && (wcnt == len - 1'b1)) begin
                  pkt_avail        <= 1'b1;
                  pkt_region_begin <= BUF_BASE;
                  pkt_region_end   <= BUF_BASE + ADDR_W'(len) - 1'b1;
                  state            <= RX_AVAIL;
               end else if (frame_end && (wtaken != len)) begin
                  rx_err <= 1'b1;
                  state  <= RX_IDLE;
               end else if (word_done && (wtaken != len)) begin
                  if (mem_we && !mem_ack) begin
                     rx_err <= 1'b1;
                     state  <= RX_DRAIN;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_addr  <= BUF_BASE + ADDR_W'(wtaken);
                     mem_wdata <= DATA_W'(word);
                     wtaken    <= wtaken + 1'b1;
                  end
               end
            end
            RX_DRAIN: begin
               if (!frame_active) state <= RX_IDLE;
            end
            RX_AVAIL: begin
               if (done) begin
                  pkt_avail <= 1'b0;
                  state     <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_pkt_rx.sv
// tb/tb_spi_pkt_rx.sv - self-checking bench for spi_pkt_rx with a queue-based memory/packet model
module tb_spi_pkt_rx;

   localparam int                ADDR_W    = 26;
   localparam int                DATA_W    = 32;
   localparam int                MAX_WORDS = 6;
   localparam logic [ADDR_W-1:0] BUF_BASE  = 26'h100;
   localparam int                H         = 3;

   logic              clk = 1'b0;
   logic              rst_l = 1'b0;
   logic              spi_sclk = 1'b0;
   logic              spi_mosi = 1'b0;
   logic              spi_ss_n = 1'b1;
   logic              mem_ack = 1'b0;
   logic              done = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [ADDR_W-1:0] pkt_region_begin;
   logic [ADDR_W-1:0] pkt_region_end;
   logic              pkt_avail;
   logic              rx_busy;
   logic              rx_err;

   spi_pkt_rx #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BUF_BASE  (BUF_BASE),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk              (clk),
      .rst_l            (rst_l),
      .spi_sclk         (spi_sclk),
      .spi_mosi         (spi_mosi),
      .spi_ss_n         (spi_ss_n),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_we           (mem_we),
      .mem_ack          (mem_ack),
      .pkt_region_begin (pkt_region_begin),
      .pkt_region_end   (pkt_region_end),
      .pkt_avail        (pkt_avail),
      .done             (done),
      .rx_busy          (rx_busy),
      .rx_err           (rx_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ack_delay = 0;
   int stall = 0;
   int err_cnt = 0;
   int avail_rise = 0;
   int last_ack_cyc = 0;
   int avail_cyc = 0;
   logic avail_q = 1'b0;
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   logic [7:0]        tx[$];

   // Memory responder and event recorder; a write is logged when the ack is presented
   always @(negedge clk) begin
      cyc++;
      if (rx_err) err_cnt++;
      if (pkt_avail && !avail_q) begin
         avail_rise++;
         avail_cyc = cyc;
      end
      avail_q = pkt_avail;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_we) begin
         if (stall >= ack_delay) begin
            mem_ack = 1'b1;
            stall = 0;
            last_ack_cyc = cyc;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
         end else begin
            stall++;
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = b[i];
         repeat (H) @(posedge clk);
         spi_sclk = 1'b1;
         repeat (H) @(posedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic send_frame();
      spi_ss_n = 1'b0;
      repeat (2 * H) @(posedge clk);
      foreach (tx[i]) spi_byte(tx[i]);
      repeat (2 * H) @(posedge clk);
      spi_ss_n = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic build(input int len_field, input int nbytes);
      tx.delete();
      for (int k = 0; k < 4; k++) tx.push_back(8'(len_field >> (8 * k)));
      for (int k = 0; k < nbytes; k++) tx.push_back(8'($urandom));
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic wait_avail();
      for (int i = 0; i < 3000 && !pkt_avail; i++) @(negedge clk);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   // Payload word w of the frame in tx: byte 4w is the least significant
   function automatic logic [31:0] model_word(input int w);
      logic [31:0] v = 32'd0;
      for (int k = 0; k < 4; k++) v = v + ({24'd0, tx[4 + 4 * w + k]} << (8 * k));
      return v;
   endfunction

   task automatic test_reset();
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({mem_we, pkt_avail, rx_busy, rx_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {mem_we, pkt_avail, rx_busy, rx_err}); end
      n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata); end
      n_cmp++; if (pkt_region_begin !== '0 || pkt_region_end !== '0) begin n_bad++; $display("FAIL reset_region got %h/%h want 0/0", pkt_region_begin, pkt_region_end); end
      rst_l = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle got %b want 0", rx_busy); end
   endtask

   task automatic test_basic();
      build(2, 0);
      for (int k = 1; k <= 8; k++) tx.push_back(8'(k * 'h11));
      clear_log();
      send_frame();
      wait_avail();
      n_cmp++; if (wr_data_q.size() !== 2) begin n_bad++; $display("FAIL basic_nwr got %0d want 2", wr_data_q.size()); end
      n_cmp++; if (wr_data_q[0] !== 32'h44332211 || wr_addr_q[0] !== BUF_BASE) begin n_bad++; $display("FAIL basic_wr0 got %h@%h want 44332211@%h", wr_data_q[0], wr_addr_q[0], BUF_BASE); end
      n_cmp++; if (wr_data_q[1] !== 32'h88776655 || wr_addr_q[1] !== BUF_BASE + 1) begin n_bad++; $display("FAIL basic_wr1 got %h@%h want 88776655@%h", wr_data_q[1], wr_addr_q[1], BUF_BASE + 1); end
      n_cmp++; if (pkt_avail !== 1'b1) begin n_bad++; $display("FAIL basic_avail got %b want 1", pkt_avail); end
      n_cmp++; if (pkt_region_begin !== BUF_BASE || pkt_region_end !== BUF_BASE + 1) begin n_bad++; $display("FAIL basic_region got %h..%h want %h..%h", pkt_region_begin, pkt_region_end, BUF_BASE, BUF_BASE + 1); end
      n_cmp++; if (avail_cyc !== last_ack_cyc + 1) begin n_bad++; $display("FAIL basic_avail_lat got %0d want %0d", avail_cyc, last_ack_cyc + 1); end
      pulse_done();
      n_cmp++; if (pkt_avail !== 1'b0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL basic_done got avail=%b busy=%b want 0/0", pkt_avail, rx_busy); end
   endtask

   task automatic test_bad_len();
      int e0 = err_cnt;
      int a0 = avail_rise;
      clear_log();
      build(0, 4);
      send_frame();
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL len0_err got %0d want 1", err_cnt - e0); end
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL len0_idle got %b want 0", rx_busy); end
      build(MAX_WORDS + 1, 8);
      send_frame();
      n_cmp++; if (err_cnt - e0 !== 2) begin n_bad++; $display("FAIL lenmax_err got %0d want 2", err_cnt - e0); end
      n_cmp++; if (wr_data_q.size() !== 0 || avail_rise !== a0) begin n_bad++; $display("FAIL badlen_quiet got wr=%0d avail=%0d want 0/0", wr_data_q.size(), avail_rise - a0); end
   endtask

   task automatic test_abort();
      int e0 = err_cnt;
      int a0 = avail_rise;
      clear_log();
      build(4, 6);
      send_frame();
      n_cmp++; if (wr_data_q.size() !== 1) begin n_bad++; $display("FAIL abort_nwr got %0d want 1", wr_data_q.size()); end
      n_cmp++; if (wr_data_q[0] !== model_word(0) || wr_addr_q[0] !== BUF_BASE) begin n_bad++; $display("FAIL abort_wr0 got %h@%h want %h@%h", wr_data_q[0], wr_addr_q[0], model_word(0), BUF_BASE); end
      n_cmp++; if (err_cnt - e0 !== 1 || avail_rise !== a0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL abort_state got err=%0d avail=%0d busy=%b want 1/0/0", err_cnt - e0, avail_rise - a0, rx_busy); end
   endtask

   task automatic test_overrun();
      int e0 = err_cnt;
      int a0 = avail_rise;
      clear_log();
      stall = 0;
      ack_delay = 300;
      build(3, 12);
      send_frame();
      repeat (20) @(negedge clk);
      ack_delay = 0;
      n_cmp++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== model_word(0)) begin n_bad++; $display("FAIL overrun_wr got n=%0d d=%h want 1/%h", wr_data_q.size(), wr_data_q[0], model_word(0)); end
      n_cmp++; if (err_cnt - e0 !== 1 || avail_rise !== a0) begin n_bad++; $display("FAIL overrun_err got err=%0d avail=%0d want 1/0", err_cnt - e0, avail_rise - a0); end
      n_cmp++; if (mem_we !== 1'b0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL overrun_idle got we=%b busy=%b want 0/0", mem_we, rx_busy); end
   endtask

   task automatic test_avail_hold();
      int len = $urandom_range(1, 3);
      int e0;
      logic [ADDR_W-1:0] exp_end;
      clear_log();
      build(len, 4 * len);
      send_frame();
      wait_avail();
      exp_end = BUF_BASE + ADDR_W'(len - 1);
      n_cmp++; if (pkt_avail !== 1'b1 || pkt_region_end !== exp_end) begin n_bad++; $display("FAIL hold_first got avail=%b end=%h want 1/%h", pkt_avail, pkt_region_end, exp_end); end
      clear_log();
      e0 = err_cnt;
      build(1, 4);
      repeat (100) @(negedge clk);
      send_frame();
      n_cmp++; if (wr_data_q.size() !== 0 || err_cnt !== e0) begin n_bad++; $display("FAIL hold_ignore got wr=%0d err=%0d want 0/0", wr_data_q.size(), err_cnt - e0); end
      n_cmp++; if (pkt_avail !== 1'b1 || pkt_region_begin !== BUF_BASE || pkt_region_end !== exp_end) begin n_bad++; $display("FAIL hold_stable got %b %h..%h want 1 %h..%h", pkt_avail, pkt_region_begin, pkt_region_end, BUF_BASE, exp_end); end
      pulse_done();
      n_cmp++; if (pkt_avail !== 1'b0) begin n_bad++; $display("FAIL hold_done got %b want 0", pkt_avail); end
      len = $urandom_range(1, MAX_WORDS);
      build(len, 4 * len);
      send_frame();
      wait_avail();
      n_cmp++; if (wr_data_q.size() !== len || pkt_region_end !== BUF_BASE + ADDR_W'(len - 1)) begin n_bad++; $display("FAIL hold_fresh got n=%0d end=%h want %0d/%h", wr_data_q.size(), pkt_region_end, len, BUF_BASE + ADDR_W'(len - 1)); end
      for (int i = 0; i < len; i++) begin
         n_cmp++; if (wr_data_q[i] !== model_word(i) || wr_addr_q[i] !== BUF_BASE + ADDR_W'(i)) begin n_bad++; $display("FAIL hold_fresh_wr%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], model_word(i), BUF_BASE + ADDR_W'(i)); end
      end
      pulse_done();
   endtask

   task automatic test_reset_mid();
      int len;
      clear_log();
      build(3, 5);
      spi_ss_n = 1'b0;
      repeat (2 * H) @(posedge clk);
      foreach (tx[i]) spi_byte(tx[i]);
      repeat (10) @(negedge clk);
      n_cmp++; if (wr_data_q.size() !== 1 || rx_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got wr=%0d busy=%b want 1/1", wr_data_q.size(), rx_busy); end
      @(posedge clk);
      #2 rst_l = 1'b0;
      #1;
      n_cmp++; if ({mem_we, pkt_avail, rx_busy, rx_err} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL rstmid_outs got %b %h %h want 0000 0 0", {mem_we, pkt_avail, rx_busy, rx_err}, mem_addr, mem_wdata); end
      spi_ss_n = 1'b1;
      spi_sclk = 1'b0;
      repeat (5) @(negedge clk);
      rst_l = 1'b1;
      repeat (5) @(negedge clk);
      clear_log();
      len = $urandom_range(1, MAX_WORDS);
      build(len, 4 * len);
      send_frame();
      wait_avail();
      n_cmp++; if (pkt_avail !== 1'b1 || wr_data_q.size() !== len) begin n_bad++; $display("FAIL rstmid_next got avail=%b n=%0d want 1/%0d", pkt_avail, wr_data_q.size(), len); end
      for (int i = 0; i < len; i++) begin
         n_cmp++; if (wr_data_q[i] !== model_word(i) || wr_addr_q[i] !== BUF_BASE + ADDR_W'(i)) begin n_bad++; $display("FAIL rstmid_wr%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], model_word(i), BUF_BASE + ADDR_W'(i)); end
      end
      pulse_done();
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int len = (r == 0) ? MAX_WORDS : $urandom_range(1, MAX_WORDS);
         int extra = $urandom_range(0, 3);
         int e0 = err_cnt;
         ack_delay = $urandom_range(0, 4);
         clear_log();
         build(len, 4 * len + extra);
         send_frame();
         wait_avail();
         n_cmp++; if (pkt_avail !== 1'b1 || wr_data_q.size() !== len || err_cnt !== e0) begin n_bad++; $display("FAIL rand%0d_pkt got avail=%b n=%0d err=%0d want 1/%0d/0", r, pkt_avail, wr_data_q.size(), err_cnt - e0, len); end
         n_cmp++; if (pkt_region_begin !== BUF_BASE || pkt_region_end !== BUF_BASE + ADDR_W'(len - 1)) begin n_bad++; $display("FAIL rand%0d_region got %h..%h want %h..%h", r, pkt_region_begin, pkt_region_end, BUF_BASE, BUF_BASE + ADDR_W'(len - 1)); end
         for (int i = 0; i < len; i++) begin
            n_cmp++; if (wr_data_q[i] !== model_word(i) || wr_addr_q[i] !== BUF_BASE + ADDR_W'(i)) begin n_bad++; $display("FAIL rand%0d_wr%0d got %h@%h want %h@%h", r, i, wr_data_q[i], wr_addr_q[i], model_word(i), BUF_BASE + ADDR_W'(i)); end
         end
         pulse_done();
         n_cmp++; if (pkt_avail !== 1'b0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL rand%0d_done got avail=%b busy=%b want 0/0", r, pkt_avail, rx_busy); end
      end
      ack_delay = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_len();
      test_abort();
      test_overrun();
      test_avail_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
